// File: rtl/fetch_pc_unit.sv
// Instruction-fetch front end: owns the PC, drives the imem request handshake,
// delivers instructions to decode and applies execute-stage redirects.
module fetch_pc_unit #(
  parameter int                  DATA_WIDTH = 32,
  parameter int                  PC_WIDTH   = 20,
  parameter logic [PC_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable_in,
  input  logic                  stall_in,
  input  logic                  select_new_pc_in,
  input  logic [PC_WIDTH-1:0]   new_pc_in,
  output logic                  imem_req_out,
  output logic [PC_WIDTH-1:0]   imem_addr_out,
  input  logic                  imem_ack_in,
  input  logic [DATA_WIDTH-1:0] imem_data_in,
  output logic [DATA_WIDTH-1:0] inst_out,
  output logic                  inst_valid_out,
  output logic [PC_WIDTH-1:0]   pc_out,
  output logic                  flush_out
);

  typedef enum logic [1:0] {IDLE, REQ, DROP, HOLD} state_t;

  state_t                state;
  logic [PC_WIDTH-1:0]   pc_reg;
  logic [PC_WIDTH-1:0]   hold_pc;
  logic [DATA_WIDTH-1:0] hold_data;
  logic [PC_WIDTH-1:0]   pc_inc;
  logic [PC_WIDTH-1:0]   redirect_pc;
  logic                  out_busy;

  // Wraps modulo 2^PC_WIDTH by construction of the sum width.
  assign pc_inc      = pc_reg + PC_WIDTH'(4);
  assign redirect_pc = new_pc_in & ~PC_WIDTH'(3);
  assign out_busy    = inst_valid_out & stall_in;

  // The hold buffer is full exactly when state == HOLD, so it needs no valid bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      pc_reg         <= RESET_PC;
      hold_pc        <= '0;
      hold_data      <= '0;
      imem_req_out   <= 1'b0;
      imem_addr_out  <= '0;
      inst_out       <= '0;
      inst_valid_out <= 1'b0;
      pc_out         <= '0;
      flush_out      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout; later assignments in this
      // block override the defaults below without creating ordering hazards.
      flush_out <= 1'b0;
      if (!stall_in) inst_valid_out <= 1'b0;

      if (select_new_pc_in) begin
        pc_reg         <= redirect_pc;
        inst_valid_out <= 1'b0;
        flush_out      <= 1'b1;
        unique case (state)
          IDLE: state <= IDLE;
          REQ, DROP: begin
            if (imem_ack_in) begin
              // The old request completes now; its data is discarded.
              if (enable_in) begin
                state         <= REQ;
                imem_req_out  <= 1'b1;
                imem_addr_out <= redirect_pc;
              end else begin
                state        <= IDLE;
                imem_req_out <= 1'b0;
              end
            end else begin
              // A request cannot be withdrawn; wait it out on the old address.
              state <= DROP;
            end
          end
          HOLD: begin
            if (enable_in) begin
              state         <= REQ;
              imem_req_out  <= 1'b1;
              imem_addr_out <= redirect_pc;
            end else begin
              state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end else begin
        unique case (state)
          IDLE: begin
            if (enable_in) begin
              state         <= REQ;
              imem_req_out  <= 1'b1;
              imem_addr_out <= pc_reg;
            end
          end
          REQ: begin
            if (imem_ack_in) begin
              pc_reg <= pc_inc;
              if (!out_busy) begin
                inst_out       <= imem_data_in;
                pc_out         <= imem_addr_out;
                inst_valid_out <= 1'b1;
                if (enable_in) begin
                  imem_addr_out <= pc_inc;
                end else begin
                  state        <= IDLE;
                  imem_req_out <= 1'b0;
                end
              end else begin
                hold_data    <= imem_data_in;
                hold_pc      <= imem_addr_out;
                state        <= HOLD;
                imem_req_out <= 1'b0;
              end
            end
          end
          HOLD: begin
            if (!stall_in) begin
              inst_out       <= hold_data;
              pc_out         <= hold_pc;
              inst_valid_out <= 1'b1;
              if (enable_in) begin
                state         <= REQ;
                imem_req_out  <= 1'b1;
                imem_addr_out <= pc_reg;
              end else begin
                state <= IDLE;
              end
            end
          end
          DROP: begin
            if (imem_ack_in) begin
              if (enable_in) begin
                state         <= REQ;
                imem_addr_out <= pc_reg;
              end else begin
                state        <= IDLE;
                imem_req_out <= 1'b0;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit: streaming, stall/hold, redirects, PC wrap
// and asynchronous reset, with a zero/variable-wait memory model.
module tb_fetch_pc_unit;

  localparam int DW = 32;
  localparam int PW = 20;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable_in;
  logic          stall_in;
  logic          select_new_pc_in;
  logic [PW-1:0] new_pc_in;
  logic          ack_en;

  logic          imem_req_out, imem_ack_in, inst_valid_out, flush_out;
  logic [PW-1:0] imem_addr_out, pc_out;
  logic [DW-1:0] imem_data_in, inst_out;

  logic          w_req, w_ack, w_valid, w_flush;
  logic [PW-1:0] w_addr, w_pc;
  logic [DW-1:0] w_data, w_inst;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Memory returns addr | 0xA5000000 whenever acking is enabled.
  assign imem_ack_in  = imem_req_out & ack_en;
  assign imem_data_in = 32'hA500_0000 | {12'h0, imem_addr_out};
  assign w_ack        = w_req & ack_en;
  assign w_data       = 32'hA500_0000 | {12'h0, w_addr};

  fetch_pc_unit #(.DATA_WIDTH(DW), .PC_WIDTH(PW), .RESET_PC(20'h00000)) dut (
    .clk(clk), .rst_n(rst_n), .enable_in(enable_in), .stall_in(stall_in),
    .select_new_pc_in(select_new_pc_in), .new_pc_in(new_pc_in),
    .imem_req_out(imem_req_out), .imem_addr_out(imem_addr_out),
    .imem_ack_in(imem_ack_in), .imem_data_in(imem_data_in),
    .inst_out(inst_out), .inst_valid_out(inst_valid_out),
    .pc_out(pc_out), .flush_out(flush_out)
  );

  fetch_pc_unit #(.DATA_WIDTH(DW), .PC_WIDTH(PW), .RESET_PC(20'hFFFFC)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .enable_in(enable_in), .stall_in(stall_in),
    .select_new_pc_in(1'b0), .new_pc_in(new_pc_in),
    .imem_req_out(w_req), .imem_addr_out(w_addr),
    .imem_ack_in(w_ack), .imem_data_in(w_data),
    .inst_out(w_inst), .inst_valid_out(w_valid),
    .pc_out(w_pc), .flush_out(w_flush)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " req"},   32'(imem_req_out),   32'h0);
    check({tag, " addr"},  32'(imem_addr_out),  32'h0);
    check({tag, " inst"},  inst_out,            32'h0);
    check({tag, " valid"}, 32'(inst_valid_out), 32'h0);
    check({tag, " pc"},    32'(pc_out),         32'h0);
    check({tag, " flush"}, 32'(flush_out),      32'h0);
  endtask

  initial begin
    rst_n = 1'b0; enable_in = 1'b0; stall_in = 1'b0;
    select_new_pc_in = 1'b0; new_pc_in = '0; ack_en = 1'b1;
    #2;
    check_all_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    enable_in = 1'b1;

    // Streaming at zero-wait memory.
    step();
    check("s0 req",  32'(imem_req_out), 32'h1);
    check("s0 addr", 32'(imem_addr_out), 32'h0);
    check("s0 valid", 32'(inst_valid_out), 32'h0);
    check("wrap s0 addr", 32'(w_addr), 32'hFFFFC);
    step();
    check("s1 addr", 32'(imem_addr_out), 32'h4);
    check("s1 valid", 32'(inst_valid_out), 32'h1);
    check("s1 pc", 32'(pc_out), 32'h0);
    check("s1 inst", inst_out, 32'hA500_0000);
    check("wrap s1 addr", 32'(w_addr), 32'h00000);
    check("wrap s1 pc", 32'(w_pc), 32'hFFFFC);
    check("wrap s1 inst", w_inst, 32'hA50F_FFFC);
    step();
    check("s2 addr", 32'(imem_addr_out), 32'h8);
    check("s2 pc", 32'(pc_out), 32'h4);
    check("s2 inst", inst_out, 32'hA500_0004);

    // Stall for 3 cycles while 0x8 is acked into the hold buffer.
    stall_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("hold%0d req", i), 32'(imem_req_out), 32'h0);
      check($sformatf("hold%0d pc", i), 32'(pc_out), 32'h4);
      check($sformatf("hold%0d inst", i), inst_out, 32'hA500_0004);
      check($sformatf("hold%0d valid", i), 32'(inst_valid_out), 32'h1);
    end
    stall_in = 1'b0;
    step();
    check("unhold pc", 32'(pc_out), 32'h8);
    check("unhold inst", inst_out, 32'hA500_0008);
    check("unhold valid", 32'(inst_valid_out), 32'h1);
    check("unhold req", 32'(imem_req_out), 32'h1);
    check("unhold addr", 32'(imem_addr_out), 32'hC);
    step();
    check("post pc", 32'(pc_out), 32'hC);
    check("post addr", 32'(imem_addr_out), 32'h10);

    // Redirect to 0x103 while the 0x10 request waits two cycles for ack.
    ack_en = 1'b0;
    select_new_pc_in = 1'b1;
    new_pc_in = 20'h00103;
    step();
    select_new_pc_in = 1'b0;
    check("drop0 flush", 32'(flush_out), 32'h1);
    check("drop0 valid", 32'(inst_valid_out), 32'h0);
    check("drop0 req", 32'(imem_req_out), 32'h1);
    check("drop0 addr", 32'(imem_addr_out), 32'h10);
    step();
    check("drop1 flush", 32'(flush_out), 32'h0);
    check("drop1 addr", 32'(imem_addr_out), 32'h10);
    ack_en = 1'b1;
    step();
    check("drop2 addr", 32'(imem_addr_out), 32'h100);
    check("drop2 valid", 32'(inst_valid_out), 32'h0);
    check("drop2 flush", 32'(flush_out), 32'h0);
    step();
    check("tgt valid", 32'(inst_valid_out), 32'h1);
    check("tgt pc", 32'(pc_out), 32'h100);
    check("tgt inst", inst_out, 32'hA500_0100);
    check("tgt addr", 32'(imem_addr_out), 32'h104);

    // Redirect coinciding with an ack and a stall.
    stall_in = 1'b1;
    select_new_pc_in = 1'b1;
    new_pc_in = 20'h00200;
    step();
    select_new_pc_in = 1'b0;
    stall_in = 1'b0;
    check("rack valid", 32'(inst_valid_out), 32'h0);
    check("rack flush", 32'(flush_out), 32'h1);
    check("rack addr", 32'(imem_addr_out), 32'h200);
    check("rack req", 32'(imem_req_out), 32'h1);
    step();
    check("rack2 pc", 32'(pc_out), 32'h200);
    check("rack2 valid", 32'(inst_valid_out), 32'h1);
    check("rack2 flush", 32'(flush_out), 32'h0);

    // Enter DROP, then reset asynchronously mid-cycle.
    ack_en = 1'b0;
    select_new_pc_in = 1'b1;
    new_pc_in = 20'h00300;
    step();
    select_new_pc_in = 1'b0;
    check("pre-rst flush", 32'(flush_out), 32'h1);
    check("pre-rst req", 32'(imem_req_out), 32'h1);
    #1 rst_n = 1'b0;
    #1;
    check_all_zero("async rst");
    @(negedge clk);
    rst_n = 1'b1;
    ack_en = 1'b1;
    step();
    check("rst req", 32'(imem_req_out), 32'h1);
    check("rst addr", 32'(imem_addr_out), 32'h0);
    check("wrap rst addr", 32'(w_addr), 32'hFFFFC);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
Instruction-fetch front end. It owns the program counter and drives the instruction-memory request handshake. It delivers fetched instructions and their PC to decode. It consumes the redirect pair (select_new_pc, target pc) produced by execute-stage branch/jump control. It applies each redirect, squashing wrong-path fetches and in-flight memory returns.

Parameters:
DATA_WIDTH, 32, instruction/memory data width
PC_WIDTH, 20, byte-address PC width; PC is word-aligned, [1:0] always 00
RESET_PC, 0, PC value loaded on reset

Ports:
clk  input  1  core clock, rising edge
rst_n  input  1  asynchronous active-low reset
enable_in  input  1  core run enable; gates issue of new fetches
stall_in  input  1  decode cannot accept a new instruction this cycle
select_new_pc_in  input  1  redirect strobe from execute, one-cycle pulse
new_pc_in  input  PC_WIDTH  redirect target; bits [1:0] ignored (treated as 00)
imem_req_out  output  1  instruction memory request
imem_addr_out  output  PC_WIDTH  request address, stable while imem_req_out=1
imem_ack_in  input  1  memory returns data this cycle for the outstanding request
imem_data_in  input  DATA_WIDTH  returned instruction, valid with imem_ack_in
inst_out  output  DATA_WIDTH  instruction to decode
inst_valid_out  output  1  inst_out/pc_out valid
pc_out  output  PC_WIDTH  address of inst_out
flush_out  output  1  kill the decode-stage instruction, one-cycle pulse

Behaviour:
- Reset (async, rst_n=0):
  - pc_reg=RESET_PC, state=IDLE, hold buffer empty.
  - All outputs 0: imem_req_out, imem_addr_out, inst_out, inst_valid_out, pc_out, flush_out.
- All outputs are registered.
- States: IDLE, REQ, DROP, HOLD.
- IDLE:
  - imem_req_out=0.
  - If enable_in=1, go to REQ next cycle with imem_addr_out=pc_reg.
- REQ:
  - imem_req_out=1; address held constant until imem_ack_in.
  - On ack with output free (inst_valid_out=0 or stall_in=0): next cycle inst_out=imem_data_in, pc_out=imem_addr_out, inst_valid_out=1, pc_reg=pc_reg+4.
    - If enable_in=1, a new request issues the next cycle (back-to-back, one instruction per cycle at zero-wait memory).
    - Otherwise go to IDLE.
  - On ack with output busy (inst_valid_out=1 and stall_in=1): data and address go into the one-entry hold buffer, pc_reg+=4, go to HOLD.
- HOLD:
  - imem_req_out=0.
  - Output registers frozen while stall_in=1.
  - When stall_in=0: buffer moves to inst_out/pc_out (valid stays 1), buffer empties, go to REQ (or IDLE if enable_in=0).
- Output handshake:
  - When stall_in=0 and no new data arrives, inst_valid_out clears next cycle (instruction consumed).
  - While stall_in=1, inst_out/pc_out/inst_valid_out hold.
- Redirect (select_new_pc_in=1) overrides stall_in and enable_in:
  - pc_reg={new_pc_in[PC_WIDTH-1:2],2'b00}.
  - inst_valid_out=0 next cycle; hold buffer cleared.
  - flush_out=1 for exactly the next cycle.
  - Per state:
    - IDLE: stay IDLE.
    - HOLD: go to REQ at new pc if enable_in=1, else IDLE.
    - REQ without ack the same cycle: go to DROP. imem_req_out and imem_addr_out stay on the old request; the memory protocol forbids withdrawing a request.
    - REQ with ack the same cycle: returned data discarded, next request uses the new pc.
    - DROP: another redirect overwrites pc_reg again; still DROP.
- DROP:
  - imem_req_out=1 on the old address.
  - On ack, data discarded (never reaches inst_out); go to REQ at pc_reg (IDLE if enable_in=0).
- Arithmetic: pc_reg+4 is modulo 2^PC_WIDTH; the maximum word-aligned address wraps to 0.
- Reset mid-transaction returns to IDLE immediately. Memory must tolerate a dropped request.

Test Plan:
- Reset then enable_in=1, zero-wait memory acking every cycle with data=addr|0xA5000000:
  - imem_addr_out = 0x00000, 0x00004, 0x00008 on consecutive cycles.
  - inst_valid_out=1 from the cycle after the first ack, pc_out following one cycle behind.
- stall_in=1 for 3 cycles while addr 0x8 is acked:
  - inst_out(pc 0x4) held; 0x8 sits in the hold buffer; imem_req_out=0.
  - After stall drops, pc_out=0x8, then the fetch of 0xC.
  - No instruction lost or duplicated.
- Redirect to 0x00103 with the memory delaying ack for 2 cycles on addr 0x10:
  - imem_addr_out stays 0x10 until ack; that data is discarded.
  - flush_out pulses once; next request is at 0x00100.
  - inst_valid_out=0 until 0x100 returns.
- Redirect in the same cycle as an ack and as stall_in=1:
  - Returned data discarded, inst_valid_out=0 next cycle, flush_out=1; next addr = target.
- PC wrap: RESET_PC=0xFFFFC, acks continuous -> second request address 0x00000.
- Reset asserted while in DROP -> all outputs 0 asynchronously; after release with enable_in=1, first request at RESET_PC.
